// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer: operator-driven register file + ALU.
// Four level strobes are edge-detected and walk a small sequencer. It captures the register
// pair, then the op/mode, then an optional immediate, then executes. Each op reads R[rdest]
// and R[rsrc] or the immediate, and writes the result back at WB. Flags are updated at WB.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   data_input [IN_W-1:0]      switch bus, sampled on strobe rising edges
//   ld_reg/ld_setup/ld_imm/ld_exec   level strobes
//   flags [4:0]                {C,L,F,Z,N}
//   rd_data [DATA_W-1:0]       last written value (CMP: operand A)
//   busy                       high while EXEC/WB
//   done                       1-cycle pulse when an op retires
//   err                        1-cycle pulse on an illegal strobe or op
//   dbg_addr/dbg_data          only with REGFILE_DEBUG_EN: combinational register peek
//
// Optional feature macro: REGFILE_DEBUG_EN
module regfile_alu_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IN_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   data_input,
  input  logic              ld_reg,
  input  logic              ld_setup,
  input  logic              ld_imm,
  input  logic              ld_exec,
  output logic [4:0]        flags,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
`endif
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);

  // Flag bit positions inside {C,L,F,Z,N}
  localparam int unsigned FC = 4;
  localparam int unsigned FL = 3;
  localparam int unsigned FF = 2;
  localparam int unsigned FZ = 1;
  localparam int unsigned FN = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_HAVE_REG, S_HAVE_SETUP, S_HAVE_IMM, S_EXEC, S_WB
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        strobe_q;
  logic [3:0]        rise;
  logic              pick_exec, pick_imm, pick_setup, pick_reg;
  logic [RA_W-1:0]   rdest_q, rsrc_q;
  logic [3:0]        op_q;
  logic              imm_mode_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic cap_reg_c, cap_setup_c, cap_imm_c, go_exec_c, err_c;

  // Rising-edge detect; only the highest-priority rise is evaluated
  assign rise       = {ld_exec, ld_imm, ld_setup, ld_reg} & ~strobe_q;
  assign pick_exec  = rise[3];
  assign pick_imm   = rise[2] & ~rise[3];
  assign pick_setup = rise[1] & ~|rise[3:2];
  assign pick_reg   = rise[0] & ~|rise[3:1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: begin
        if (go_exec_c)        state_d = S_EXEC;
        else if (cap_imm_c)   state_d = S_HAVE_IMM;
        else if (cap_setup_c) state_d = S_HAVE_SETUP;
        else if (cap_reg_c)   state_d = S_HAVE_REG;
      end
    endcase
  end

  // Acceptance decode: which picked rise is legal in the current state
  always_comb begin
    cap_reg_c   = 1'b0;
    cap_setup_c = 1'b0;
    cap_imm_c   = 1'b0;
    go_exec_c   = 1'b0;
    err_c       = 1'b0;
    case (state_q)
      S_IDLE:       cap_reg_c = pick_reg;
      S_HAVE_REG: begin
        cap_reg_c   = pick_reg;
        cap_setup_c = pick_setup;
      end
      S_HAVE_SETUP: begin
        cap_reg_c = pick_reg;
        cap_imm_c = pick_imm;
        go_exec_c = pick_exec & ~imm_mode_q;
      end
      S_HAVE_IMM: begin
        cap_reg_c = pick_reg;
        go_exec_c = pick_exec;
      end
      default: ;
    endcase
    // Strobes are ignored silently while an op is in flight
    if (state_q != S_EXEC && state_q != S_WB)
      err_c = (|rise) & ~(cap_reg_c | cap_setup_c | cap_imm_c | go_exec_c);
  end

  // ALU: operands are read at WB, before the write, so rdest==rsrc aliasing sees old data
  logic [DATA_W-1:0] op_a, op_b, res_c, rd_next_c;
  logic [DATA_W:0]   sum_c, diff_c;
  logic [4:0]        flags_next_c;
  logic              wr_c, upd_c, zn_c;

  always_comb begin
    op_a         = regs[rdest_q];
    op_b         = imm_mode_q ? imm_q : regs[rsrc_q];
    sum_c        = {1'b0, op_a} + {1'b0, op_b};
    diff_c       = {1'b0, op_a} - {1'b0, op_b};
    res_c        = '0;
    flags_next_c = flags;
    rd_next_c    = rd_data;
    wr_c         = 1'b1;
    upd_c        = 1'b1;
    zn_c         = 1'b1;
    case (op_q)
      4'd0: begin
        res_c            = sum_c[DATA_W-1:0];
        flags_next_c[FC] = sum_c[DATA_W];
        flags_next_c[FF] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                           (res_c[DATA_W-1] != op_a[DATA_W-1]);
      end
      4'd1: begin
        res_c            = diff_c[DATA_W-1:0];
        flags_next_c[FC] = diff_c[DATA_W];
        flags_next_c[FF] = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                           (res_c[DATA_W-1] != op_a[DATA_W-1]);
      end
      4'd2: res_c = op_a & op_b;
      4'd3: res_c = op_a | op_b;
      4'd4: res_c = op_a ^ op_b;
      4'd5: res_c = op_b;
      4'd6: begin
        wr_c             = 1'b0;
        zn_c             = 1'b0;
        rd_next_c        = op_a;
        flags_next_c[FZ] = (op_a == op_b);
        flags_next_c[FL] = (op_a < op_b);
        flags_next_c[FN] = ($signed(op_a) < $signed(op_b));
      end
      4'd7: res_c = op_a << op_b[3:0];
      default: begin
        wr_c  = 1'b0;
        upd_c = 1'b0;
        zn_c  = 1'b0;
      end
    endcase
    if (zn_c) begin
      flags_next_c[FZ] = (res_c == '0);
      flags_next_c[FN] = res_c[DATA_W-1];
      rd_next_c        = res_c;
    end
  end

  // Captures, register file, flags and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q   <= '0;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      op_q       <= '0;
      imm_mode_q <= 1'b0;
      imm_q      <= '0;
      flags      <= '0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      strobe_q <= {ld_exec, ld_imm, ld_setup, ld_reg};
      if (cap_reg_c) begin
        rdest_q <= data_input[2*RA_W-1:RA_W];
        rsrc_q  <= data_input[RA_W-1:0];
      end
      if (cap_setup_c) begin
        op_q       <= data_input[3:0];
        imm_mode_q <= data_input[4];
      end
      if (cap_imm_c) imm_q <= DATA_W'(data_input);
      busy <= (state_d == S_EXEC) || (state_d == S_WB);
      done <= (state_q == S_WB);
      err  <= err_c || ((state_q == S_WB) && !upd_c);
      if (state_q == S_WB && upd_c) begin
        flags   <= flags_next_c;
        rd_data <= rd_next_c;
        if (wr_c) regs[rdest_q] <= res_c;
      end
    end
  end

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench for regfile_alu_sequencer (DATA_W=16, NUM_REGS=16, IN_W=10).
module tb_regfile_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  data_input;
  logic        ld_reg, ld_setup, ld_imm, ld_exec;
  logic [4:0]  flags;
  logic [15:0] rd_data;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  regfile_alu_sequencer #(.DATA_W(16), .NUM_REGS(16), .IN_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_input (data_input),
    .ld_reg     (ld_reg),
    .ld_setup   (ld_setup),
    .ld_imm     (ld_imm),
    .ld_exec    (ld_exec),
    .flags      (flags),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge right after the sampling edge
  task automatic pulse(input int which, input logic [9:0] data);
    @(negedge clk);
    data_input = data;
    case (which)
      0: ld_reg   = 1'b1;
      1: ld_setup = 1'b1;
      2: ld_imm   = 1'b1;
      default: ld_exec = 1'b1;
    endcase
    @(negedge clk);
    ld_reg = 1'b0; ld_setup = 1'b0; ld_imm = 1'b0; ld_exec = 1'b0;
  endtask

  // Exec strobe (optionally with ld_reg) and exact-latency retirement checks
  task automatic run_exec(input string tag, input logic with_reg, input logic [9:0] data,
                          input logic [15:0] exp_rd, input logic [4:0] exp_flags,
                          input logic exp_err);
    @(negedge clk);
    data_input = data;
    ld_exec = 1'b1;
    ld_reg  = with_reg;
    @(negedge clk);
    ld_exec = 1'b0; ld_reg = 1'b0;
    check({tag, "_busy_e"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_wb"}, 32'(busy), 32'd1);
    check({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_rd"}, 32'(rd_data), 32'(exp_rd));
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  task automatic do_op(input string tag, input int rd, input int rs, input int op,
                       input logic im, input logic [9:0] imm,
                       input logic [15:0] exp_rd, input logic [4:0] exp_flags,
                       input logic exp_err);
    pulse(0, 10'({4'(rd), 4'(rs)}));
    pulse(1, 10'({im, 4'(op)}));
    if (im) pulse(2, imm);
    run_exec(tag, 1'b0, 10'd0, exp_rd, exp_flags, exp_err);
  endtask

  logic saw_err;

  initial begin
    rst_n = 1'b0;
    data_input = '0;
    ld_reg = 1'b0; ld_setup = 1'b0; ld_imm = 1'b0; ld_exec = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // flags are {C,L,F,Z,N}
    do_op("mov_r3",    3, 0, 5, 1'b1, 10'h155, 16'h0155, 5'b00000, 1'b0);
    do_op("add_r3",    3, 0, 0, 1'b1, 10'h2AB, 16'h0400, 5'b00000, 1'b0);
    do_op("sub_r3",    3, 0, 1, 1'b1, 10'h200, 16'h0200, 5'b00000, 1'b0);
    do_op("sub_r3z",   3, 0, 1, 1'b1, 10'h200, 16'h0000, 5'b00010, 1'b0);
    do_op("mov_r4",    4, 0, 5, 1'b1, 10'h000, 16'h0000, 5'b00010, 1'b0);
    do_op("sub_r4",    4, 0, 1, 1'b1, 10'h001, 16'hFFFF, 5'b10001, 1'b0);
    do_op("add_r4",    4, 0, 0, 1'b1, 10'h001, 16'h0000, 5'b10010, 1'b0);
    do_op("mov_r3b",   3, 0, 5, 1'b1, 10'h155, 16'h0155, 5'b10000, 1'b0);
    do_op("cmp_r3",    3, 0, 6, 1'b1, 10'h200, 16'h0155, 5'b11001, 1'b0);
    do_op("mov_r6_r3", 6, 3, 5, 1'b0, 10'h000, 16'h0155, 5'b11000, 1'b0);
    do_op("add_alias", 3, 3, 0, 1'b0, 10'h000, 16'h02AA, 5'b01000, 1'b0);
    do_op("lsh_r3",    3, 0, 7, 1'b1, 10'h004, 16'h2AA0, 5'b01000, 1'b0);
    do_op("illegal",   3, 0, 9, 1'b1, 10'h005, 16'h2AA0, 5'b01000, 1'b1);
    do_op("and_r3",    5, 3, 2, 1'b0, 10'h000, 16'h0000, 5'b01010, 1'b0);
    do_op("xor_r3",    3, 0, 4, 1'b1, 10'h3FF, 16'h295F, 5'b01000, 1'b0);
    do_op("or_r3",     3, 0, 3, 1'b1, 10'h0A0, 16'h29FF, 5'b01000, 1'b0);

    // ld_imm in IDLE is illegal and leaves the state at IDLE
    pulse(2, 10'h011);
    check("idle_imm_err", 32'(err), 32'd1);
    @(negedge clk);
    check("idle_err_1cyc", 32'(err), 32'd0);
    pulse(1, 10'h015);
    check("idle_setup_err", 32'(err), 32'd1);

    // ld_setup held for 5 cycles in HAVE_REG captures once
    pulse(0, 10'h070);
    @(negedge clk);
    data_input = 10'h015;
    ld_setup = 1'b1;
    saw_err = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_err |= err;
    end
    ld_setup = 1'b0;
    check("hold_no_err", 32'(saw_err), 32'd0);
    pulse(2, 10'h03C);
    check("hold_imm_ok", 32'(err), 32'd0);
    run_exec("hold_exec", 1'b0, 10'd0, 16'h003C, 5'b01000, 1'b0);

    // ld_exec and ld_reg together in HAVE_IMM: exec wins
    pulse(0, 10'h080);
    pulse(1, 10'h015);
    pulse(2, 10'h077);
    run_exec("exec_and_reg", 1'b1, 10'h012, 16'h0077, 5'b01000, 1'b0);

    // Reset during EXEC discards the op; registers clear
    pulse(0, 10'h030);
    pulse(1, 10'h015);
    pulse(2, 10'h234);
    pulse(3, 10'h000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_err = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_err |= done;
    end
    check("rst_mid_done", 32'(saw_err), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rd", 32'(rd_data), 32'd0);
    check("rst_mid_flags", 32'(flags), 32'd0);
    do_op("read_r3", 9, 3, 5, 1'b0, 10'h000, 16'h0000, 5'b00010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
